// File: rtl/lsu_ctrl.sv
// Load/store controller between the memory stage and data_mem.
// Three-phase access (IDLE -> EXEC -> RESP); bad-range or bad-funct3 requests never reach memory.
module lsu_ctrl #(
  parameter int ADDRESS_WIDTH = 17,
  parameter int DATA_WIDTH    = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_we,
  input  logic [2:0]               req_funct3,
  input  logic [31:0]              req_addr,
  input  logic [DATA_WIDTH-1:0]    req_wdata,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [DATA_WIDTH-1:0]    rsp_rdata,
  output logic                     rsp_err,
  output logic [ADDRESS_WIDTH-1:0] mem_a,
  output logic [DATA_WIDTH-1:0]    mem_wd,
  output logic                     mem_we0,
  output logic                     mem_we1,
  output logic                     mem_we2,
  output logic                     mem_we3,
  input  logic [DATA_WIDTH-1:0]    mem_rd
);

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_t;

  state_t                     state_q, state_d;
  logic                       we_q;
  logic [2:0]                 funct3_q;
  logic [ADDRESS_WIDTH-1:0]   addr_q;
  logic [DATA_WIDTH-1:0]      wdata_q;
  logic                       err_q;
  logic [DATA_WIDTH-1:0]      rsp_rdata_q;
  logic                       rsp_err_q;

  logic [32:0]                size;
  logic [32:0]                end_addr;
  logic                       funct3_bad;
  logic                       req_err;
  logic [DATA_WIDTH-1:0]      load_ext;
  logic                       store_en;

  // Range check is done on the 33-bit end address so wrap past the top byte is caught.
  always_comb begin
    case (req_funct3[1:0])
      2'd0:    size = 33'd1;
      2'd1:    size = 33'd2;
      default: size = 33'd4;
    endcase
    end_addr = {1'b0, req_addr} + size;
    if (req_we)
      funct3_bad = (req_funct3 >= 3'd3);
    else
      funct3_bad = (req_funct3 == 3'd3) || (req_funct3 == 3'd6) || (req_funct3 == 3'd7);
    req_err = funct3_bad || (end_addr > (33'd1 << ADDRESS_WIDTH));
  end

  always_comb begin
    case (funct3_q)
      3'd0:    load_ext = {{24{mem_rd[7]}}, mem_rd[7:0]};
      3'd1:    load_ext = {{16{mem_rd[15]}}, mem_rd[15:0]};
      3'd2:    load_ext = mem_rd;
      3'd4:    load_ext = {24'd0, mem_rd[7:0]};
      3'd5:    load_ext = {16'd0, mem_rd[15:0]};
      default: load_ext = '0;
    endcase
  end

  // Byte for A+n travels on mem_wd[31-8n -: 8], i.e. lanes are reversed relative to mem_rd.
  always_comb begin
    case (funct3_q[1:0])
      2'd0:    mem_wd = {wdata_q[7:0], 24'd0};
      2'd1:    mem_wd = {wdata_q[7:0], wdata_q[15:8], 16'd0};
      default: mem_wd = {wdata_q[7:0], wdata_q[15:8], wdata_q[23:16], wdata_q[31:24]};
    endcase
  end

  assign mem_a     = addr_q;
  assign store_en  = (state_q == S_EXEC) && we_q && !err_q;
  assign mem_we0   = store_en;
  assign mem_we1   = store_en && (funct3_q[1:0] != 2'd0);
  assign mem_we2   = store_en && (funct3_q[1:0] == 2'd2);
  assign mem_we3   = store_en && (funct3_q[1:0] == 2'd2);
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

  always_comb begin
    state_d   = state_q;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    case (state_q)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_d = S_EXEC;
      end
      S_EXEC: state_d = S_RESP;
      S_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      we_q        <= 1'b0;
      funct3_q    <= 3'd0;
      addr_q      <= '0;
      wdata_q     <= '0;
      err_q       <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == S_IDLE && req_valid) begin
        we_q     <= req_we;
        funct3_q <= req_funct3;
        addr_q   <= req_addr[ADDRESS_WIDTH-1:0];
        wdata_q  <= req_wdata;
        err_q    <= req_err;
      end
      if (state_q == S_EXEC) begin
        rsp_rdata_q <= (!we_q && !err_q) ? load_ext : '0;
        rsp_err_q   <= err_q;
      end
      if (state_q == S_RESP && rsp_ready) begin
        rsp_rdata_q <= '0;
        rsp_err_q   <= 1'b0;
      end
    end
  end

endmodule
